plru_state_array: RTL and testbench



---
 rtl/plru_state_array_if.sv | 28 ++
 rtl/plru_state_array.sv | 129 ++++++++++++
 tb/tb_plru_state_array.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/plru_state_array_if.sv
// Access-update and eviction-read bundle between the cache pipeline and the PLRU state store.
// master = cache pipeline driving updates and read set; slave = plru_state_array.
interface plru_state_array_if #(
    parameter int ASSOCIATIVITY = 8,
    parameter int SETS          = 64
);
    localparam int SW = $clog2(SETS);
    localparam int WW = $clog2(ASSOCIATIVITY);
    localparam int NB = ASSOCIATIVITY - 1;

    logic          upd_valid;
    logic          upd_ready;
    logic [SW-1:0] upd_set;
    logic [WW-1:0] upd_way;
    logic [SW-1:0] rd_set;
    logic [NB-1:0] lru_bits;
    logic          init_busy;

    modport master (
        output upd_valid, upd_set, upd_way, rd_set,
        input  upd_ready, lru_bits, init_busy
    );

    modport slave (
        input  upd_valid, upd_set, upd_way, rd_set,
        output upd_ready, lru_bits, init_busy
    );
endinterface

// File: rtl/plru_state_array.sv
// Per-set tree PLRU store: zero-fill sweep after reset, then MRU update of the accessed way per access.
// Latency: update accepted at E0 is written at E1, seen on lru_bits at E2 (E1 with PLRU_RD_FWD_EN).
// Backpressure: upd_ready low only during the SETS-cycle init sweep; one update per cycle in RUN.
module plru_state_array #(
    parameter int ASSOCIATIVITY = 8,
    parameter int SETS          = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    plru_state_array_if.slave bus
);
    localparam int SW = $clog2(SETS);
    localparam int WW = $clog2(ASSOCIATIVITY);
    localparam int NB = ASSOCIATIVITY - 1;

    typedef enum logic {INIT, RUN} state_t;

    state_t        state;
    logic [SW-1:0] ic;
    logic          upd_ready;
    logic          init_busy;
    logic [NB-1:0] lru_bits;

    logic          s1_vld;
    logic [SW-1:0] s1_set;
    logic [WW-1:0] s1_way;

    logic [NB-1:0] mem [SETS];

    logic          accept;
    logic [NB-1:0] s2_old;
    logic [NB-1:0] s2_new;
    logic          wr_en;
    logic [SW-1:0] wr_set;
    logic [NB-1:0] wr_dat;

    // Walk root to leaf along the way index (MSB first), pointing each visited node away from it.
    function automatic logic [NB-1:0] mru_update(input logic [NB-1:0] bits_in,
                                                 input logic [WW-1:0] way);
        logic [NB-1:0] bits;
        logic [WW-1:0] w;
        logic [WW-1:0] node;
        logic          b;
        bits = bits_in;
        w    = way;
        node = '0;
        for (int l = 0; l < WW; l++) begin
            b          = w[WW-1];
            bits[node] = ~b;
            node       = (node << 1) + (b ? WW'(2) : WW'(1));
            w          = w << 1;
        end
        return bits;
    endfunction

    assign accept = bus.upd_valid && upd_ready;
    assign s2_old = mem[s1_set];
    assign s2_new = mru_update(s2_old, s1_way);

    always_comb begin
        wr_en  = 1'b0;
        wr_set = '0;
        wr_dat = '0;
        if (state == INIT) begin
            wr_en  = 1'b1;
            wr_set = ic;
        end else if (s1_vld) begin
            wr_en  = 1'b1;
            wr_set = s1_set;
            wr_dat = s2_new;
        end
    end

    // A reset edge suppresses the write so an in-flight S2 update is discarded.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem[wr_set] <= wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= INIT;
            ic        <= '0;
            upd_ready <= 1'b0;
            init_busy <= 1'b1;
            s1_vld    <= 1'b0;
            s1_set    <= '0;
            s1_way    <= '0;
            lru_bits  <= '0;
        end else begin
            case (state)
                INIT: begin
                    ic <= ic + 1'b1;
                    if (ic == SW'(SETS - 1)) begin
                        state     <= RUN;
                        upd_ready <= 1'b1;
                        init_busy <= 1'b0;
                    end
                end
                RUN: begin
                    upd_ready <= 1'b1;
                    init_busy <= 1'b0;
                end
                default: state <= INIT;
            endcase

            s1_vld <= accept;
            if (accept) begin
                s1_set <= bus.upd_set;
                s1_way <= bus.upd_way;
            end

`ifdef PLRU_RD_FWD_EN
            if (s1_vld && state == RUN && bus.rd_set == s1_set) begin
                lru_bits <= s2_new;
            end else begin
                lru_bits <= mem[bus.rd_set];
            end
`else
            lru_bits <= mem[bus.rd_set];
`endif
        end
    end

    assign bus.upd_ready = upd_ready;
    assign bus.init_busy = init_busy;
    assign bus.lru_bits  = lru_bits;
endmodule

// File: tb/tb_plru_state_array.sv
// Directed bench for plru_state_array (ASSOCIATIVITY=8, SETS=64); expectations hand-derived from the tree walk.
module tb_plru_state_array;
    localparam int ASSOC = 8;
    localparam int SETS  = 64;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    int   busy_cnt;
    int   edge_cnt;

    plru_state_array_if #(.ASSOCIATIVITY(ASSOC), .SETS(SETS)) bus ();

    plru_state_array #(.ASSOCIATIVITY(ASSOC), .SETS(SETS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Independent victim walk: 1 goes right, 0 goes left, way bits MSB first.
    function automatic logic [2:0] victim(input logic [6:0] b);
        logic [2:0] v;
        int         n;
        n = 0;
        v = '0;
        for (int l = 0; l < 3; l++) begin
            v[2-l] = b[n];
            n = b[n] ? 2 * n + 2 : 2 * n + 1;
        end
        return v;
    endfunction

    task automatic drive(input logic vld, input logic [5:0] s, input logic [2:0] w);
        bus.upd_valid = vld;
        bus.upd_set   = s;
        bus.upd_way   = w;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        drive(1'b0, 6'd0, 3'd0);
        bus.rd_set = 6'd0;

        tick();
        tick();
        chk("rst_init_busy", {31'd0, bus.init_busy}, 32'd1);
        chk("rst_upd_ready", {31'd0, bus.upd_ready}, 32'd0);
        chk("rst_lru_bits", {25'd0, bus.lru_bits}, 32'd0);

        // Init sweep with an update request held the whole time.
        rst_n = 1'b1;
        drive(1'b1, 6'd2, 3'd1);
        bus.rd_set = 6'd5;
        busy_cnt = 0;
        for (int k = 1; k < SETS; k++) begin
            tick();
            if (bus.init_busy && !bus.upd_ready) busy_cnt++;
        end
        chk("init_busy_cycles", busy_cnt, SETS - 1);
        tick();
        drive(1'b0, 6'd0, 3'd0);
        chk("init_done_busy", {31'd0, bus.init_busy}, 32'd0);
        chk("init_done_ready", {31'd0, bus.upd_ready}, 32'd1);
        chk("set5_cleared", {25'd0, bus.lru_bits}, 32'd0);
        bus.rd_set = 6'd2;
        tick();
        chk("set2_no_init_upd", {25'd0, bus.lru_bits}, 32'd0);

        // Set 3, way 0 -> nodes 0,1,3 set.
        drive(1'b1, 6'd3, 3'd0);
        bus.rd_set = 6'd3;
        tick();
        drive(1'b0, 6'd0, 3'd0);
        chk("w0_e0", {25'd0, bus.lru_bits}, 32'd0);
        tick();
`ifdef PLRU_RD_FWD_EN
        chk("w0_e1", {25'd0, bus.lru_bits}, 32'h0B);
`else
        chk("w0_e1", {25'd0, bus.lru_bits}, 32'd0);
`endif
        tick();
        chk("w0_e2", {25'd0, bus.lru_bits}, 32'h0B);
        chk("w0_victim", {29'd0, victim(bus.lru_bits)}, 32'd4);

        // Set 3, way 7 -> nodes 0,2,6 cleared, node 1 and 3 kept.
        drive(1'b1, 6'd3, 3'd7);
        tick();
        drive(1'b0, 6'd0, 3'd0);
        tick();
        tick();
        chk("w7_bits", {25'd0, bus.lru_bits}, 32'h0A);
        chk("w7_victim", {29'd0, victim(bus.lru_bits)}, 32'd2);

        // Set 4 back-to-back way 0 then way 4.
        drive(1'b1, 6'd4, 3'd0);
        bus.rd_set = 6'd4;
        tick();
        drive(1'b1, 6'd4, 3'd4);
        tick();
        drive(1'b0, 6'd0, 3'd0);
        tick();
`ifdef PLRU_RD_FWD_EN
        chk("b2b_mid", {25'd0, bus.lru_bits}, 32'h2E);
`else
        chk("b2b_mid", {25'd0, bus.lru_bits}, 32'h0B);
`endif
        tick();
        chk("b2b_final", {25'd0, bus.lru_bits}, 32'h2E);
        chk("b2b_victim", {29'd0, victim(bus.lru_bits)}, 32'd2);

        // Set 7 way 6 with rd_set held on 7: read-after-update latency.
        drive(1'b1, 6'd7, 3'd6);
        bus.rd_set = 6'd7;
        tick();
        drive(1'b0, 6'd0, 3'd0);
        chk("lat_e0", {25'd0, bus.lru_bits}, 32'd0);
        tick();
`ifdef PLRU_RD_FWD_EN
        chk("lat_e1", {25'd0, bus.lru_bits}, 32'h40);
`else
        chk("lat_e1", {25'd0, bus.lru_bits}, 32'd0);
`endif
        tick();
        chk("lat_e2", {25'd0, bus.lru_bits}, 32'h40);

        // Reset lands on the edge where set 9 / way 3 would be written.
        drive(1'b1, 6'd9, 3'd3);
        bus.rd_set = 6'd9;
        tick();
        drive(1'b0, 6'd0, 3'd0);
        rst_n = 1'b0;
        tick();
        chk("rerst_busy", {31'd0, bus.init_busy}, 32'd1);
        chk("rerst_ready", {31'd0, bus.upd_ready}, 32'd0);
        chk("rerst_lru", {25'd0, bus.lru_bits}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rerst_write_dropped", {25'd0, bus.lru_bits}, 32'd0);
        bus.rd_set = 6'd3;
        tick();
        tick();
        tick();
        chk("sweep_set3_before", {25'd0, bus.lru_bits}, 32'h0A);
        tick();
        chk("sweep_set3_after", {25'd0, bus.lru_bits}, 32'd0);
        edge_cnt = 5;
        while (!bus.upd_ready && edge_cnt < 200) begin
            tick();
            edge_cnt++;
        end
        chk("resweep_len", edge_cnt, SETS);
        chk("resweep_busy", {31'd0, bus.init_busy}, 32'd0);
        for (int s = 0; s < SETS; s++) begin
            bus.rd_set = 6'(s);
            tick();
            chk($sformatf("resweep_set%0d", s), {25'd0, bus.lru_bits}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
